// File: rtl/blit_vidfetch.sv
// Display-side framebuffer fetcher: reads words sequentially over the RAM
// request/ack bus into a small FIFO and shifts them out MSB-first as pixels.
module blit_vidfetch #(
    parameter int FRAME_WORDS = 51200,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [17:0] fb_base,
    input  logic        vid_start,
    input  logic        pix_en,
    output logic        pix_out,
    output logic        underflow,
    output logic        ram_req,
    output logic [17:0] ram_addr,
    output logic [15:0] ram_wdata,
    output logic [1:0]  ram_wstrb,
    output logic        ram_we,
    input  logic        ram_ack,
    input  logic [15:0] ram_rdata
);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;
    localparam int FCW = $clog2(FRAME_WORDS + 1);

    typedef enum logic [0:0] {S_IDLE, S_WAIT} state_t;

    state_t         r_state;
    state_t         w_state_next;

    logic [15:0]    r_fifo [FIFO_DEPTH];
    logic [PW-1:0]  r_wptr;
    logic [PW-1:0]  r_rptr;
    logic [CW-1:0]  r_count;
    logic [15:0]    r_shreg;
    logic [3:0]     r_shcnt;
    logic [FCW-1:0] r_fetched;
    logic [17:0]    r_addr;
    logic           r_discard;
    logic           r_ram_req;
    logic [17:0]    r_ram_addr;
    logic           r_pix;
    logic           r_underflow;

    logic           w_can_issue;
    logic           w_issue;
    logic           w_accept;
    logic           w_push;
    logic           w_pop;
    logic [15:0]    w_head;

    // A request is only issued when the FIFO has room for the word it returns.
    assign w_can_issue = (r_fetched < FCW'(FRAME_WORDS)) &&
                         (r_count < CW'(FIFO_DEPTH)) && !vid_start;
    assign w_push      = w_accept && !r_discard && !vid_start;
    assign w_pop       = pix_en && !vid_start && (r_shcnt == 4'd0) && (r_count != '0);
    assign w_head      = r_fifo[r_rptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_can_issue) w_state_next = S_WAIT;
            S_WAIT: if (ram_ack)     w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_issue  = 1'b0;
        w_accept = 1'b0;
        case (r_state)
            S_IDLE: w_issue  = w_can_issue;
            S_WAIT: w_accept = ram_ack;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ram_req  <= 1'b0;
            r_ram_addr <= '0;
            r_addr     <= '0;
            r_fetched  <= FCW'(FRAME_WORDS);
            r_discard  <= 1'b0;
        end else begin
            r_ram_req <= w_issue;
            if (w_issue) r_ram_addr <= r_addr;
            if (vid_start) begin
                r_addr    <= fb_base & ~18'd1;
                r_fetched <= '0;
            end else if (w_push) begin
                r_addr    <= r_addr + 18'd2;
                r_fetched <= r_fetched + FCW'(1);
            end
            // A restart during WAIT leaves one stale ack in flight; drop it.
            if (w_accept) begin
                r_discard <= 1'b0;
            end else if (vid_start && (r_state == S_WAIT)) begin
                r_discard <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wptr] <= ram_rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (vid_start) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pix       <= 1'b0;
            r_underflow <= 1'b0;
            r_shreg     <= '0;
            r_shcnt     <= '0;
        end else if (vid_start) begin
            r_pix       <= 1'b0;
            r_underflow <= 1'b0;
            r_shcnt     <= '0;
        end else if (pix_en) begin
            if (r_shcnt != 4'd0) begin
                r_pix   <= r_shreg[15];
                r_shreg <= {r_shreg[14:0], 1'b0};
                r_shcnt <= r_shcnt - 4'd1;
            end else if (r_count != '0) begin
                // Loading straight from the FIFO head keeps full-rate output gapless.
                r_pix   <= w_head[15];
                r_shreg <= {w_head[14:0], 1'b0};
                r_shcnt <= 4'd15;
            end else begin
                r_pix       <= 1'b0;
                r_underflow <= 1'b1;
            end
        end
    end

    assign ram_req   = r_ram_req;
    assign ram_addr  = r_ram_addr;
    assign pix_out   = r_pix;
    assign underflow = r_underflow;
    assign ram_wdata = '0;
    assign ram_wstrb = '0;
    assign ram_we    = 1'b0;

endmodule

// File: tb/tb_blit_vidfetch.sv
// Bench for blit_vidfetch: a pixel-queue reference model checked every cycle,
// a latency-configurable RAM responder, directed scenarios and a random run.
module tb_blit_vidfetch;
    localparam int FW    = 24;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [17:0] fb_base = '0;
    logic        vid_start = 1'b0;
    logic        pix_en = 1'b0;
    logic        ram_ack = 1'b0;
    logic [15:0] ram_rdata = '0;
    logic        pix_out, underflow, ram_req, ram_we;
    logic [17:0] ram_addr;
    logic [15:0] ram_wdata;
    logic [1:0]  ram_wstrb;

    blit_vidfetch #(.FRAME_WORDS(FW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .fb_base(fb_base), .vid_start(vid_start),
        .pix_en(pix_en), .pix_out(pix_out), .underflow(underflow),
        .ram_req(ram_req), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_wstrb(ram_wstrb), .ram_we(ram_we), .ram_ack(ram_ack),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: the FIFO plus shift register is one queue of pending pixels.
    bit          m_req, m_pix, m_uf, m_wait, m_disc;
    logic [17:0] m_ram_addr, m_addr;
    int          m_fetched;
    bit          m_bits[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_req = 0; m_ram_addr = '0; m_pix = 0; m_uf = 0; m_wait = 0; m_disc = 0;
            m_addr = '0; m_fetched = FW; m_bits.delete();
        end else begin
            bit push;
            push = 0;
            if (m_wait) begin
                m_req = 0;
                if (ram_ack) begin
                    m_wait = 0;
                    if (m_disc) m_disc = 0;
                    else if (!vid_start) push = 1;
                end else if (vid_start) begin
                    m_disc = 1;
                end
            end else if (!vid_start && m_fetched < FW && (m_bits.size() / 16) < DEPTH) begin
                m_req = 1; m_ram_addr = m_addr; m_wait = 1;
            end else begin
                m_req = 0;
            end
            if (vid_start) begin
                m_bits.delete();
                m_addr = fb_base & ~18'd1;
                m_fetched = 0; m_uf = 0; m_pix = 0;
            end else begin
                if (pix_en) begin
                    if (m_bits.size() > 0) m_pix = m_bits.pop_front();
                    else begin m_pix = 0; m_uf = 1; end
                end
                if (push) begin
                    for (int b = 15; b >= 0; b--) m_bits.push_back(ram_rdata[b]);
                    m_addr = m_addr + 18'd2;
                    m_fetched++;
                end
            end
        end
    end

    // Responder state
    int          lat_cur = 1;
    bit          lat_rand = 0;
    int          pend = 0;
    int          nreq = 0;
    logic [17:0] req_addr = '0, first_addr = '0, last_addr = '0;
    bit          data_lin = 1;
    logic [17:0] data_base = '0;

    function automatic logic [15:0] data_for(input logic [17:0] a);
        logic [17:0] d;
        if (data_lin) begin
            d = (a - data_base) >> 1;
            return d[15:0];
        end
        return (a[16:1] * 16'h9E37) ^ 16'h5A3C;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
        end
    endtask

    // One clock: compare DUT with the model, then drive the responder for the next cycle.
    task automatic cycle();
        @(posedge clk); #1;
        check("cycle_outputs",
              {ram_req, ram_addr, pix_out, underflow, ram_wdata, ram_wstrb, ram_we},
              {m_req, m_ram_addr, m_pix, m_uf, 16'h0, 2'b00, 1'b0});
        ram_ack = 1'b0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                ram_ack   = 1'b1;
                ram_rdata = data_for(req_addr);
            end
        end
        if (ram_req === 1'b1) begin
            check("single_outstanding", (pend != 0) || ram_ack, 0);
            pend     = lat_rand ? $urandom_range(1, 6) : lat_cur;
            req_addr = ram_addr;
            nreq++;
            if (nreq == 1) first_addr = ram_addr;
            last_addr = ram_addr;
        end
    endtask

    task automatic start(input logic [17:0] base);
        fb_base   = base;
        vid_start = 1'b1;
        nreq      = 0;
        cycle();
        vid_start = 1'b0;
    endtask

    initial begin
        logic [31:0] cap;
        int w;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_outputs", {ram_req, ram_addr, pix_out, underflow}, 0);
        repeat (5) cycle();
        check("idle_before_start", nreq, 0);

        // Fill with pix_en low: eight requests, then stall.
        data_lin = 1; data_base = 18'h01000; lat_cur = 1; lat_rand = 0;
        start(18'h01000);
        repeat (60) cycle();
        check("fill_nreq", nreq, 8);
        check("fill_first_addr", first_addr, 18'h01000);
        check("fill_last_addr", last_addr, 18'h0100E);

        // Full-rate drain: word 0 then word 1 MSB-first, no gap.
        pix_en = 1'b1;
        cap = '0;
        for (int i = 0; i < 32; i++) begin
            cycle();
            cap = {cap[30:0], pix_out};
        end
        check("first_32_pixels", cap, 32'h0000_0001);
        check("no_underflow_full_rate", underflow, 0);

        // Run past the end of the frame.
        repeat (420) cycle();
        check("frame_nreq", nreq, FW);
        repeat (30) cycle();
        check("frame_stopped", nreq, FW);
        pix_en = 1'b0;

        // Restart while waiting on a 3-cycle ack.
        lat_cur = 3;
        start(18'h01000);
        w = 0;
        while (nreq == 0 && w < 20) begin cycle(); w++; end
        check("wait_req_seen", nreq, 1);
        start(18'h20000);
        check("restart_pix_out", pix_out, 0);
        w = 0;
        while (nreq == 0 && w < 20) begin cycle(); w++; end
        check("restart_req_seen", nreq, 1);
        check("restart_first_addr", first_addr, 18'h20000);
        repeat (10) cycle();

        // Slow responder starves the pixel stream.
        data_lin = 0; lat_cur = 5;
        start(18'h00000);
        pix_en = 1'b1;
        repeat (20) cycle();
        check("underflow_set", underflow, 1);
        repeat (100) cycle();
        check("underflow_sticky", underflow, 1);
        start(18'h00100);
        check("underflow_cleared", underflow, 0);
        repeat (5) cycle();

        // Asynchronous reset in the middle of a wait.
        pix_en = 1'b0;
        start(18'h00400);
        w = 0;
        while (nreq == 0 && w < 20) begin cycle(); w++; end
        check("pre_rst_req_seen", nreq, 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_outputs", {ram_req, ram_addr, pix_out}, 0);
        pend = 0; ram_ack = 1'b0; nreq = 0;
        repeat (2) cycle();
        rst = 1'b0;
        repeat (20) cycle();
        check("no_req_after_rst", nreq, 0);

        // Random traffic with random ack latency and occasional restarts.
        lat_rand = 1;
        start(18'h3FFF8);
        for (int i = 0; i < 3000; i++) begin
            int dens;
            dens   = (i / 500) % 4;
            pix_en = ($urandom_range(0, 3) < dens) ? 1'b1 : 1'b0;
            if ($urandom_range(0, 299) == 0) begin
                fb_base   = 18'($urandom);
                vid_start = 1'b1;
            end
            cycle();
            vid_start = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
